// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted branches in flight from fetch to execute, retires them in order,
// updates the predictor, and sequences squash/flush/redirect when a prediction was wrong.
module branch_resolve_ctrl #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        f_valid,
   input  logic        f_pred,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_target,
   output logic        f_stall,
   input  logic        e_valid,
   input  logic        e_taken,
   input  logic [31:0] e_target,
   output logic        upd_valid,
   output logic        upd_taken,
   output logic [31:0] upd_pc,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [15:0] branch_cnt,
   output logic [15:0] mispred_cnt,
   output logic        err
);

   localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
   localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {RUN, FLUSH} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t        state;
   logic [2:0]    flush_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic          q_pred   [DEPTH];
   logic [31:0]   q_pc     [DEPTH];
   logic [31:0]   q_target [DEPTH];

   logic          push, pop, mispred, empty_resolve;
   logic          head_pred;
   logic [31:0]   head_pc, head_target, correct_pc;

   assign f_stall       = (count == FULL) | (state == FLUSH);
   assign push          = f_valid & ~f_stall;
   assign pop           = e_valid & (state == RUN) & (count != '0);
   assign empty_resolve = e_valid & (state == RUN) & (count == '0);

   assign head_pred   = q_pred[rd_ptr];
   assign head_pc     = q_pc[rd_ptr];
   assign head_target = q_target[rd_ptr];
   assign mispred     = pop & ((head_pred != e_taken) |
                               (e_taken & head_pred & (head_target != e_target)));
   assign correct_pc  = e_taken ? e_target : head_pc + 32'd4;

   // Queue payload carries no control meaning, so it is left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pred[wr_ptr]   <= f_pred;
         q_pc[wr_ptr]     <= f_pc;
         q_target[wr_ptr] <= f_target;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= RUN;
         flush_cnt      <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         upd_valid      <= 1'b0;
         upd_taken      <= 1'b0;
         upd_pc         <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
         err            <= 1'b0;
      end else begin
         upd_valid      <= 1'b0;
         redirect_valid <= 1'b0;
         if (empty_resolve) err <= 1'b1;
         case (state)
            RUN: begin
               if (pop) begin
                  upd_valid  <= 1'b1;
                  upd_taken  <= e_taken;
                  upd_pc     <= head_pc;
                  branch_cnt <= sat_inc(branch_cnt);
               end
               // A wrong prediction discards every younger entry, including a same-cycle push.
               if (mispred) begin
                  wr_ptr         <= '0;
                  rd_ptr         <= '0;
                  count          <= '0;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= correct_pc;
                  mispred_cnt    <= sat_inc(mispred_cnt);
                  flush          <= 1'b1;
                  flush_cnt      <= FLUSH_LOAD;
                  state          <= FLUSH;
               end else begin
                  if (push) wr_ptr <= wr_ptr + AW'(1);
                  if (pop)  rd_ptr <= rd_ptr + AW'(1);
                  if (push && !pop)      count <= count + (AW+1)'(1);
                  else if (!push && pop) count <= count - (AW+1)'(1);
               end
            end
            FLUSH: begin
               if (flush_cnt == 3'd0) begin
                  state <= RUN;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: prediction retire, both mispredict kinds,
// queue full/ordering, empty resolve and asynchronous reset during flush.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        f_valid = 1'b0, f_pred = 1'b0;
   logic [31:0] f_pc = '0, f_target = '0;
   logic        f_stall;
   logic        e_valid = 1'b0, e_taken = 1'b0;
   logic [31:0] e_target = '0;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc;
   logic        flush, redirect_valid;
   logic [31:0] redirect_pc;
   logic [15:0] branch_cnt, mispred_cnt;
   logic        err;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rstn(rstn),
      .f_valid(f_valid), .f_pred(f_pred), .f_pc(f_pc), .f_target(f_target),
      .f_stall(f_stall),
      .e_valid(e_valid), .e_taken(e_taken), .e_target(e_target),
      .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic v, input logic p, input logic [31:0] pc, input logic [31:0] tg);
      f_valid = v; f_pred = p; f_pc = pc; f_target = tg;
   endtask

   task automatic set_resolve(input logic v, input logic t, input logic [31:0] tg);
      e_valid = v; e_taken = t; e_target = tg;
   endtask

   task automatic test_reset();
      #3;
      total++; if (f_stall !== 1'b0) $display("FAIL rst_f_stall got %0h exp 0", f_stall); else passed++;
      total++; if (upd_valid !== 1'b0) $display("FAIL rst_upd_valid got %0h exp 0", upd_valid); else passed++;
      total++; if (flush !== 1'b0) $display("FAIL rst_flush got %0h exp 0", flush); else passed++;
      total++; if (redirect_valid !== 1'b0) $display("FAIL rst_redirect_valid got %0h exp 0", redirect_valid); else passed++;
      total++; if (err !== 1'b0) $display("FAIL rst_err got %0h exp 0", err); else passed++;
      total++; if (branch_cnt !== 16'd0) $display("FAIL rst_branch_cnt got %0h exp 0", branch_cnt); else passed++;
      total++; if (upd_pc !== 32'd0) $display("FAIL rst_upd_pc got %0h exp 0", upd_pc); else passed++;
      step(); step();
      rstn = 1'b1;
      step();
   endtask

   task automatic test_correct_pred();
      set_push(1'b1, 1'b1, 32'h100, 32'h140);
      step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_resolve(1'b1, 1'b1, 32'h140);
      step();
      set_resolve(1'b0, 1'b0, 32'h0);
      total++; if (upd_valid !== 1'b1) $display("FAIL corr_upd_valid got %0h exp 1", upd_valid); else passed++;
      total++; if (upd_taken !== 1'b1) $display("FAIL corr_upd_taken got %0h exp 1", upd_taken); else passed++;
      total++; if (upd_pc !== 32'h100) $display("FAIL corr_upd_pc got %0h exp 100", upd_pc); else passed++;
      total++; if (flush !== 1'b0) $display("FAIL corr_flush got %0h exp 0", flush); else passed++;
      total++; if (redirect_valid !== 1'b0) $display("FAIL corr_redirect got %0h exp 0", redirect_valid); else passed++;
      total++; if (branch_cnt !== 16'd1) $display("FAIL corr_branch_cnt got %0h exp 1", branch_cnt); else passed++;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL corr_upd_pulse got %0h exp 0", upd_valid); else passed++;
   endtask

   task automatic test_dir_mispredict();
      set_push(1'b1, 1'b1, 32'h200, 32'h240); step();
      set_push(1'b1, 1'b0, 32'h210, 32'h250); step();
      set_push(1'b1, 1'b1, 32'h220, 32'h260); step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_resolve(1'b1, 1'b0, 32'h0);
      step();
      total++; if (redirect_valid !== 1'b1) $display("FAIL dir_redirect_valid got %0h exp 1", redirect_valid); else passed++;
      total++; if (redirect_pc !== 32'h204) $display("FAIL dir_redirect_pc got %0h exp 204", redirect_pc); else passed++;
      total++; if (flush !== 1'b1) $display("FAIL dir_flush1 got %0h exp 1", flush); else passed++;
      total++; if (f_stall !== 1'b1) $display("FAIL dir_stall1 got %0h exp 1", f_stall); else passed++;
      total++; if (mispred_cnt !== 16'd1) $display("FAIL dir_mispred_cnt got %0h exp 1", mispred_cnt); else passed++;
      total++; if (upd_valid !== 1'b1 || upd_taken !== 1'b0 || upd_pc !== 32'h200)
         $display("FAIL dir_update got v=%0h t=%0h pc=%0h exp v=1 t=0 pc=200", upd_valid, upd_taken, upd_pc); else passed++;
      total++; if (branch_cnt !== 16'd2) $display("FAIL dir_branch_cnt got %0h exp 2", branch_cnt); else passed++;
      // Activity during flush must be ignored.
      set_push(1'b1, 1'b0, 32'h990, 32'h994);
      set_resolve(1'b1, 1'b1, 32'h0);
      step();
      total++; if (flush !== 1'b1) $display("FAIL dir_flush2 got %0h exp 1", flush); else passed++;
      total++; if (redirect_valid !== 1'b0) $display("FAIL dir_redirect_pulse got %0h exp 0", redirect_valid); else passed++;
      total++; if (upd_valid !== 1'b0) $display("FAIL dir_upd_in_flush got %0h exp 0", upd_valid); else passed++;
      total++; if (f_stall !== 1'b1) $display("FAIL dir_stall2 got %0h exp 1", f_stall); else passed++;
      set_resolve(1'b0, 1'b0, 32'h0);
      set_push(1'b1, 1'b1, 32'h300, 32'h300);
      step();
      total++; if (flush !== 1'b0) $display("FAIL dir_flush_end got %0h exp 0", flush); else passed++;
      total++; if (f_stall !== 1'b0) $display("FAIL dir_stall_end got %0h exp 0", f_stall); else passed++;
      total++; if (branch_cnt !== 16'd2) $display("FAIL dir_cnt_hold got %0h exp 2", branch_cnt); else passed++;
      step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_target_mispredict();
      // Head must be the 0x300 entry pushed in the first RUN cycle after the flush.
      set_resolve(1'b1, 1'b1, 32'h380);
      step();
      set_resolve(1'b0, 1'b0, 32'h0);
      total++; if (redirect_valid !== 1'b1) $display("FAIL tgt_redirect_valid got %0h exp 1", redirect_valid); else passed++;
      total++; if (redirect_pc !== 32'h380) $display("FAIL tgt_redirect_pc got %0h exp 380", redirect_pc); else passed++;
      total++; if (upd_pc !== 32'h300) $display("FAIL tgt_upd_pc got %0h exp 300", upd_pc); else passed++;
      total++; if (mispred_cnt !== 16'd2) $display("FAIL tgt_mispred_cnt got %0h exp 2", mispred_cnt); else passed++;
      total++; if (branch_cnt !== 16'd3) $display("FAIL tgt_branch_cnt got %0h exp 3", branch_cnt); else passed++;
      step(); step();
      total++; if (flush !== 1'b0) $display("FAIL tgt_flush_end got %0h exp 0", flush); else passed++;
   endtask

   task automatic test_full_queue();
      logic [31:0] exp_pc [5];
      exp_pc = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 1'b0, exp_pc[i], exp_pc[i] + 32'h8);
         step();
      end
      total++; if (f_stall !== 1'b1) $display("FAIL full_stall got %0h exp 1", f_stall); else passed++;
      set_push(1'b1, 1'b0, 32'h77, 32'h7f);
      step();
      total++; if (f_stall !== 1'b1) $display("FAIL full_stall_hold got %0h exp 1", f_stall); else passed++;
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_resolve(1'b1, 1'b0, 32'h0);
      step();
      total++; if (f_stall !== 1'b0) $display("FAIL full_stall_drop got %0h exp 0", f_stall); else passed++;
      total++; if (upd_valid !== 1'b1 || upd_pc !== exp_pc[0])
         $display("FAIL full_pop0 got v=%0h pc=%0h exp v=1 pc=%0h", upd_valid, upd_pc, exp_pc[0]); else passed++;
      // Simultaneous push and pop keeps the occupancy at three.
      set_push(1'b1, 1'b0, exp_pc[4], exp_pc[4] + 32'h8);
      step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      total++; if (upd_pc !== exp_pc[1]) $display("FAIL full_pop1 got %0h exp %0h", upd_pc, exp_pc[1]); else passed++;
      total++; if (f_stall !== 1'b0) $display("FAIL full_pushpop_stall got %0h exp 0", f_stall); else passed++;
      for (int i = 2; i < 5; i++) begin
         step();
         total++; if (upd_valid !== 1'b1 || upd_pc !== exp_pc[i])
            $display("FAIL full_pop%0d got v=%0h pc=%0h exp v=1 pc=%0h", i, upd_valid, upd_pc, exp_pc[i]); else passed++;
      end
      set_resolve(1'b0, 1'b0, 32'h0);
      step();
      total++; if (branch_cnt !== 16'd8) $display("FAIL full_branch_cnt got %0h exp 8", branch_cnt); else passed++;
      total++; if (mispred_cnt !== 16'd2) $display("FAIL full_mispred_cnt got %0h exp 2", mispred_cnt); else passed++;
      total++; if (err !== 1'b0) $display("FAIL full_err got %0h exp 0", err); else passed++;
   endtask

   task automatic test_empty_resolve();
      set_resolve(1'b1, 1'b1, 32'h123);
      step();
      set_resolve(1'b0, 1'b0, 32'h0);
      total++; if (err !== 1'b1) $display("FAIL empty_err got %0h exp 1", err); else passed++;
      total++; if (upd_valid !== 1'b0) $display("FAIL empty_upd_valid got %0h exp 0", upd_valid); else passed++;
      total++; if (branch_cnt !== 16'd8) $display("FAIL empty_branch_cnt got %0h exp 8", branch_cnt); else passed++;
      step(); step();
      total++; if (err !== 1'b1) $display("FAIL empty_err_sticky got %0h exp 1", err); else passed++;
   endtask

   task automatic test_reset_midflush();
      set_push(1'b1, 1'b1, 32'h400, 32'h440);
      step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_resolve(1'b1, 1'b0, 32'h0);
      step();
      set_resolve(1'b0, 1'b0, 32'h0);
      step();
      total++; if (flush !== 1'b1) $display("FAIL mrst_flush_before got %0h exp 1", flush); else passed++;
      #2 rstn = 1'b0;
      #1;
      total++; if (flush !== 1'b0) $display("FAIL mrst_flush got %0h exp 0", flush); else passed++;
      total++; if (f_stall !== 1'b0) $display("FAIL mrst_stall got %0h exp 0", f_stall); else passed++;
      total++; if (err !== 1'b0) $display("FAIL mrst_err got %0h exp 0", err); else passed++;
      total++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0)
         $display("FAIL mrst_counters got b=%0h m=%0h exp 0 0", branch_cnt, mispred_cnt); else passed++;
      total++; if (redirect_pc !== 32'd0) $display("FAIL mrst_redirect_pc got %0h exp 0", redirect_pc); else passed++;
      #2 rstn = 1'b1;
      set_push(1'b1, 1'b0, 32'h500, 32'h508);
      step();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_resolve(1'b1, 1'b0, 32'h0);
      step();
      set_resolve(1'b0, 1'b0, 32'h0);
      total++; if (upd_valid !== 1'b1 || upd_pc !== 32'h500)
         $display("FAIL mrst_push_after got v=%0h pc=%0h exp v=1 pc=500", upd_valid, upd_pc); else passed++;
      total++; if (branch_cnt !== 16'd1 || mispred_cnt !== 16'd0)
         $display("FAIL mrst_cnt_after got b=%0h m=%0h exp 1 0", branch_cnt, mispred_cnt); else passed++;
      total++; if (flush !== 1'b0 || err !== 1'b0)
         $display("FAIL mrst_state_after got flush=%0h err=%0h exp 0 0", flush, err); else passed++;
   endtask

   initial begin
      test_reset();
      test_correct_pred();
      test_dir_mispredict();
      test_target_mispredict();
      test_full_queue();
      test_empty_resolve();
      test_reset_midflush();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences the global-history branch predictor against the pipeline. Records every predicted branch leaving fetch in an in-order in-flight queue, and retires entries as execute resolves them. On retirement it drives the predictor update strobe and detects mispredictions. On a misprediction it squashes the queue and sequences the pipeline flush and fetch redirect. It sits between fetch (predictor lookup side), execute (resolution side) and the predictor's update port.

## Interface
- DEPTH, 4: in-flight queue entries; power of two, 2..16
- FLUSH_CYCLES, 2: cycles flush is held after a mispredict; 1..7
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- f_valid  in  1  fetch pushes a branch this cycle; ignored while f_stall=1
- f_pred  in  1  predictor output for that branch (1=taken)
- f_pc  in  32  PC of the branch
- f_target  in  32  predicted target (pre-decoded pc+imm)
- f_stall  out  1  queue full or flushing; fetch must hold
- e_valid  in  1  execute resolves the oldest outstanding branch
- e_taken  in  1  actual outcome
- e_target  in  32  actual target
- upd_valid  out  1  to predictor is_branch_prev
- upd_taken  out  1  to predictor branch_taken
- upd_pc  out  32  to predictor epc
- flush  out  1  squash all younger pipeline stages
- redirect_valid  out  1  single-cycle fetch redirect strobe
- redirect_pc  out  32  redirect address
- branch_cnt  out  16  resolved branches, saturating
- mispred_cnt  out  16  mispredictions, saturating
- err  out  1  sticky: e_valid seen with empty queue

## Operation
- Queue: circular buffer of {pred, pc, target}; wr_ptr/rd_ptr wrap modulo DEPTH; count 0..DEPTH.
- f_stall = (count==DEPTH) | (state==FLUSH), combinational from registered state only.
- Push on f_valid & !f_stall. Pop on e_valid & state==RUN & count!=0.
- Mispredict = (head.pred != e_taken) | (e_taken & head.pred & head.target != e_target).
- Correct path: if e_taken, redirect_pc = e_target; otherwise redirect_pc = head.pc + 4 (mod 2^32).
- FSM RUN: every pop sets upd_valid=1, upd_taken=e_taken, upd_pc=head.pc, and increments branch_cnt.
  - On a mispredicting pop the FSM also clears the queue (count=0, wr_ptr=rd_ptr=0), drops any same-cycle push, pulses redirect_valid, increments mispred_cnt, asserts flush, loads the flush counter with FLUSH_CYCLES-1, and enters FLUSH.
- FSM FLUSH: flush=1. f_valid and e_valid are ignored. No upd_valid is issued. The counter decrements each cycle; at 0 the FSM returns to RUN and deasserts flush.
- e_valid with count==0 in RUN: no pop, no update, err set until reset.
- Push and pop in the same cycle with no mispredict: count unchanged.
- Counters hold at 16'hFFFF.

## Timing
- All outputs except f_stall are registered. The update, redirect and flush outputs appear in cycle N+1 for e_valid in cycle N.
- upd_valid and redirect_valid are 1-cycle pulses. flush is high for exactly FLUSH_CYCLES cycles, starting together with redirect_valid.
- The first push after a flush is accepted in the first RUN cycle, i.e. FLUSH_CYCLES+1 cycles after the mispredicting e_valid.
- A pushed entry can be popped no earlier than the next cycle. Same-cycle push and pop on an empty queue is treated as a pop from empty.
- Reset (asynchronous, any state, including mid-flush) forces:
  - state=RUN and the queue empty;
  - f_stall, upd_valid, upd_taken, flush, redirect_valid and err all 0;
  - upd_pc, redirect_pc, branch_cnt and mispred_cnt all 0.
- Operation resumes on the first clk edge after rstn deasserts.

## Test plan
- Correct prediction: push pred=1, pc=0x100, target=0x140; then resolve e_taken=1, e_target=0x140. Next cycle: upd_valid=1, upd_taken=1, upd_pc=0x100; flush=0; branch_cnt=1.
- Direction mispredict: queue holds 3 entries with head pred=1, pc=0x200. Resolve e_taken=0. Next cycle: redirect_valid=1, redirect_pc=0x204. flush is high for 2 cycles. Queue is empty and f_stall=1 during the flush. mispred_cnt=1.
- Target mispredict: head pred=1, target=0x300; resolve e_taken=1, e_target=0x380. Response: redirect_pc=0x380, mispred_cnt increments.
- Full queue: push 4 entries with no resolves. f_stall=1, and a 5th f_valid is ignored. One resolve drops f_stall the next cycle. Entries pop in push order (pc 0x10, 0x20, 0x30, 0x40).
- Empty resolve: e_valid with an empty queue. Response: err=1 and stays 1; upd_valid=0; branch_cnt unchanged.
- Reset mid-flush: assert rstn=0 during the 2nd flush cycle. Response: flush=0 immediately, queue empty, counters 0. After release, a push is accepted on the first edge.
